park_xform: RTL and testbench

Pipelined, parametrised forward/inverse Park transform with valid/ready handshake, convergent-free round-half-up rounding, optional saturation and a per-transaction channel tag. It sits between the Clarke transform and CORDIC sin/cos source (forward mode, feeding the d/q current loops) and between the PI controllers and SVPWM (inverse mode). It accepts one sample per cycle and stalls the whole pipeline under output backpressure.

---
 rtl/park_xform_pkg.sv | 15 +
 rtl/park_xform_if.sv | 34 +++
 rtl/park_xform_round_sat.sv | 37 +++
 rtl/park_xform.sv | 165 ++++++++++++++++
 tb/tb_park_xform.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/park_xform_pkg.sv
// Shared types, default widths and rounding helper for the park_xform pipeline.
package park_pkg;

  typedef enum logic {PARK_FWD, PARK_INV} park_mode_t;

  localparam int unsigned ParkDWidth = 18;
  localparam int unsigned ParkQBits  = 15;
  localparam int unsigned ParkTagW   = 4;

  // Half an LSB of the result, added before the arithmetic shift (round half up).
  function automatic longint park_rnd_const(input int unsigned q_bits);
    return longint'(1) << (q_bits - 1);
  endfunction

endpackage

// File: rtl/park_xform_if.sv
// Handshake, data and overflow-status bundle between park_xform and its neighbours.
interface park_xform_if
  import park_pkg::*;
#(
  parameter int unsigned D_WIDTH = ParkDWidth,
  parameter int unsigned TAG_W   = ParkTagW
);
  logic                      in_valid;
  logic                      in_ready;
  park_mode_t                in_mode;
  logic [TAG_W-1:0]          in_tag;
  logic signed [D_WIDTH-1:0] in_x;
  logic signed [D_WIDTH-1:0] in_y;
  logic signed [D_WIDTH-1:0] in_sin;
  logic signed [D_WIDTH-1:0] in_cos;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [D_WIDTH-1:0] out_u;
  logic signed [D_WIDTH-1:0] out_v;
  logic [TAG_W-1:0]          out_tag;
  logic                      out_ovf;
  logic                      ovf_sticky;
  logic                      ovf_clr;

  modport master (
    output in_valid, in_mode, in_tag, in_x, in_y, in_sin, in_cos, out_ready, ovf_clr,
    input  in_ready, out_valid, out_u, out_v, out_tag, out_ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, in_mode, in_tag, in_x, in_y, in_sin, in_cos, out_ready, ovf_clr,
    output in_ready, out_valid, out_u, out_v, out_tag, out_ovf, ovf_sticky
  );
endinterface

// File: rtl/park_xform_round_sat.sv
// Round-half-up, shift by Q_BITS and narrow one Park sum; clips when PARK_XFORM_SAT_EN
// is defined, otherwise wraps. ovf_o flags an out-of-range shifted sum in both builds.
module park_round_sat
  import park_pkg::*;
#(
  parameter int unsigned D_WIDTH = ParkDWidth,
  parameter int unsigned Q_BITS  = ParkQBits
) (
  input  logic signed [2*D_WIDTH:0]  sum_i,
  output logic signed [D_WIDTH-1:0]  res_o,
  output logic                       ovf_o
);
  localparam int unsigned SumW = 2 * D_WIDTH + 1;
  localparam int unsigned RndW = SumW + 1;
  localparam logic signed [RndW-1:0] RndConst = RndW'(park_rnd_const(Q_BITS));

  logic signed [RndW-1:0]   rnd;
  logic signed [RndW-1:0]   shf;
  logic [RndW-D_WIDTH:0]    hi;

  always_comb begin
    rnd   = {sum_i[SumW-1], sum_i} + RndConst;
    shf   = rnd >>> Q_BITS;
    // In range only if every bit above the result sign matches it.
    hi    = shf[RndW-1:D_WIDTH-1];
    ovf_o = !((&hi) || !(|hi));
`ifdef PARK_XFORM_SAT_EN
    if (ovf_o) begin
      res_o = shf[RndW-1] ? {1'b1, {(D_WIDTH-1){1'b0}}} : {1'b0, {(D_WIDTH-1){1'b1}}};
    end else begin
      res_o = shf[D_WIDTH-1:0];
    end
`else
    res_o = shf[D_WIDTH-1:0];
`endif
  end
endmodule

// File: rtl/park_xform.sv
// Three-stage forward/inverse Park transform with valid/ready backpressure.
// Define PARK_XFORM_SAT_EN to saturate results instead of wrapping them.
module park_xform
  import park_pkg::*;
#(
  parameter int unsigned D_WIDTH = ParkDWidth,
  parameter int unsigned Q_BITS  = ParkQBits,
  parameter int unsigned TAG_W   = ParkTagW
) (
  input logic         clk,
  input logic         rst,
  park_xform_if.slave bus
);
  localparam int unsigned ProdW = 2 * D_WIDTH;
  localparam int unsigned SumW  = ProdW + 1;

  logic advance;

  logic                      s1_valid_q, s1_valid_d;
  park_mode_t                s1_mode_q, s1_mode_d;
  logic [TAG_W-1:0]          s1_tag_q, s1_tag_d;
  logic signed [D_WIDTH-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic signed [D_WIDTH-1:0] s1_sin_q, s1_sin_d, s1_cos_q, s1_cos_d;

  logic                      s2_valid_q, s2_valid_d;
  park_mode_t                s2_mode_q, s2_mode_d;
  logic [TAG_W-1:0]          s2_tag_q, s2_tag_d;
  logic signed [ProdW-1:0]   s2_xc_q, s2_xc_d, s2_xs_q, s2_xs_d;
  logic signed [ProdW-1:0]   s2_yc_q, s2_yc_d, s2_ys_q, s2_ys_d;

  logic                      out_valid_q, out_valid_d;
  logic signed [D_WIDTH-1:0] out_u_q, out_u_d, out_v_q, out_v_d;
  logic [TAG_W-1:0]          out_tag_q, out_tag_d;
  logic                      out_ovf_q, out_ovf_d;
  logic                      sticky_q, sticky_d;

  logic signed [SumW-1:0]    u_sum, v_sum;
  logic signed [D_WIDTH-1:0] u_res, v_res;
  logic                      u_ovf, v_ovf;

  always_comb begin
    if (s2_mode_q == PARK_FWD) begin
      u_sum = {s2_xc_q[ProdW-1], s2_xc_q} + {s2_ys_q[ProdW-1], s2_ys_q};
      v_sum = {s2_yc_q[ProdW-1], s2_yc_q} - {s2_xs_q[ProdW-1], s2_xs_q};
    end else begin
      u_sum = {s2_xc_q[ProdW-1], s2_xc_q} - {s2_ys_q[ProdW-1], s2_ys_q};
      v_sum = {s2_xs_q[ProdW-1], s2_xs_q} + {s2_yc_q[ProdW-1], s2_yc_q};
    end
  end

  park_round_sat #(.D_WIDTH(D_WIDTH), .Q_BITS(Q_BITS)) u_round_u (
    .sum_i (u_sum),
    .res_o (u_res),
    .ovf_o (u_ovf)
  );

  park_round_sat #(.D_WIDTH(D_WIDTH), .Q_BITS(Q_BITS)) u_round_v (
    .sum_i (v_sum),
    .res_o (v_res),
    .ovf_o (v_ovf)
  );

  always_comb begin
    advance     = !out_valid_q || bus.out_ready;
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_tag_d    = s1_tag_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_sin_d    = s1_sin_q;
    s1_cos_d    = s1_cos_q;
    s2_valid_d  = s2_valid_q;
    s2_mode_d   = s2_mode_q;
    s2_tag_d    = s2_tag_q;
    s2_xc_d     = s2_xc_q;
    s2_xs_d     = s2_xs_q;
    s2_yc_d     = s2_yc_q;
    s2_ys_d     = s2_ys_q;
    out_valid_d = out_valid_q;
    out_u_d     = out_u_q;
    out_v_d     = out_v_q;
    out_tag_d   = out_tag_q;
    out_ovf_d   = out_ovf_q;
    if (advance) begin
      s1_valid_d  = bus.in_valid;
      s1_mode_d   = bus.in_mode;
      s1_tag_d    = bus.in_tag;
      s1_x_d      = bus.in_x;
      s1_y_d      = bus.in_y;
      s1_sin_d    = bus.in_sin;
      s1_cos_d    = bus.in_cos;
      s2_valid_d  = s1_valid_q;
      s2_mode_d   = s1_mode_q;
      s2_tag_d    = s1_tag_q;
      s2_xc_d     = ProdW'(s1_x_q) * ProdW'(s1_cos_q);
      s2_xs_d     = ProdW'(s1_x_q) * ProdW'(s1_sin_q);
      s2_yc_d     = ProdW'(s1_y_q) * ProdW'(s1_cos_q);
      s2_ys_d     = ProdW'(s1_y_q) * ProdW'(s1_sin_q);
      out_valid_d = s2_valid_q;
      // Bubbles leave the previous result visible on the output registers.
      if (s2_valid_q) begin
        out_u_d   = u_res;
        out_v_d   = v_res;
        out_tag_d = s2_tag_q;
        out_ovf_d = u_ovf || v_ovf;
      end
    end
    // A new overflow beats a coincident clear.
    sticky_d = (sticky_q && !bus.ovf_clr) || (advance && s2_valid_q && (u_ovf || v_ovf));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= PARK_FWD;
      s1_tag_q    <= '0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_sin_q    <= '0;
      s1_cos_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= PARK_FWD;
      s2_tag_q    <= '0;
      s2_xc_q     <= '0;
      s2_xs_q     <= '0;
      s2_yc_q     <= '0;
      s2_ys_q     <= '0;
      out_valid_q <= 1'b0;
      out_u_q     <= '0;
      out_v_q     <= '0;
      out_tag_q   <= '0;
      out_ovf_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_tag_q    <= s1_tag_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_sin_q    <= s1_sin_d;
      s1_cos_q    <= s1_cos_d;
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      s2_tag_q    <= s2_tag_d;
      s2_xc_q     <= s2_xc_d;
      s2_xs_q     <= s2_xs_d;
      s2_yc_q     <= s2_yc_d;
      s2_ys_q     <= s2_ys_d;
      out_valid_q <= out_valid_d;
      out_u_q     <= out_u_d;
      out_v_q     <= out_v_d;
      out_tag_q   <= out_tag_d;
      out_ovf_q   <= out_ovf_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.in_ready   = advance;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_u      = out_u_q;
  assign bus.out_v      = out_v_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_ovf    = out_ovf_q;
  assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_park_xform.sv
// Scoreboard bench for park_xform: driver pushes model results, a forked monitor checks them.
module tb_park_xform;
  import park_pkg::*;

  localparam int unsigned DW = 18;
  localparam int unsigned QB = 15;
  localparam int unsigned TW = 4;

  typedef struct {
    longint u;
    longint v;
    int     tag;
    bit     ovf;
    bit     chk_lat;
    int     acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   drv_done;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  park_xform_if #(.D_WIDTH(DW), .TAG_W(TW)) bus ();

  park_xform #(.D_WIDTH(DW), .Q_BITS(QB), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event, expected none (t=%0t)", name, $time);
  endtask

  function automatic longint narrow(input longint r);
    longint lim;
    lim = longint'(1) << (DW - 1);
`ifdef PARK_XFORM_SAT_EN
    if (r > lim - 1) return lim - 1;
    if (r < -lim) return -lim;
    return r;
`else
    r = r & ((lim << 1) - 1);
    if (r >= lim) r = r - (lim << 1);
    return r;
`endif
  endfunction

  // Reference: exact integer rotation, round half up, then narrow.
  task automatic model(input bit inv, input longint x, input longint y, input longint s,
                       input longint c, output longint u, output longint v, output bit ovf);
    longint su, sv, lim;
    lim = longint'(1) << (DW - 1);
    if (!inv) begin
      su = x * c + y * s;
      sv = y * c - x * s;
    end else begin
      su = x * c - y * s;
      sv = x * s + y * c;
    end
    su  = (su + (longint'(1) << (QB - 1))) >>> QB;
    sv  = (sv + (longint'(1) << (QB - 1))) >>> QB;
    ovf = (su > lim - 1) || (su < -lim) || (sv > lim - 1) || (sv < -lim);
    u   = narrow(su);
    v   = narrow(sv);
  endtask

  task automatic send(input park_mode_t m, input int tag, input longint x, input longint y,
                      input longint s, input longint c, input bit chk_lat);
    exp_t   e;
    longint u, v;
    bit     ovf;
    int     guard;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_tag   = TW'(tag);
    bus.in_x     = DW'(x);
    bus.in_y     = DW'(y);
    bus.in_sin   = DW'(s);
    bus.in_cos   = DW'(c);
    model(m == PARK_INV, x, y, s, c, u, v, ovf);
    guard = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        e = '{u, v, tag, ovf, chk_lat, cyc};
        exp_q.push_back(e);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 200) begin
        fail_now("send_timeout");
        break;
      end
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic monitor();
    bit                 fresh;
    bit                 matched;
    exp_t               e;
    logic signed [DW-1:0] hu, hv;
    logic [TW-1:0]      ht;
    logic               ho;
    fresh   = 1'b1;
    matched = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fresh   = 1'b1;
        matched = 1'b0;
      end else if (bus.out_valid) begin
        if (fresh) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_output");
            matched = 1'b0;
          end else begin
            e = exp_q[0];
            matched = 1'b1;
            check("out_u", bus.out_u, e.u);
            check("out_v", bus.out_v, e.v);
            check("out_tag", longint'(bus.out_tag), longint'(e.tag));
            check("out_ovf", longint'(bus.out_ovf), longint'(e.ovf));
            if (e.chk_lat) check("latency", longint'(cyc), longint'(e.acc + 3));
          end
          hu = bus.out_u;
          hv = bus.out_v;
          ht = bus.out_tag;
          ho = bus.out_ovf;
        end else begin
          check("stall_hold_u", bus.out_u, hu);
          check("stall_hold_v", bus.out_v, hv);
          check("stall_hold_tag", longint'(bus.out_tag), longint'(ht));
          check("stall_hold_ovf", longint'(bus.out_ovf), longint'(ho));
        end
        if (bus.out_ready) begin
          if (matched && exp_q.size() != 0) void'(exp_q.pop_front());
          matched = 1'b0;
          fresh   = 1'b1;
        end else begin
          fresh = 1'b0;
        end
      end
    end
  endtask

  function automatic longint rnd_data();
    return longint'($urandom_range(0, (1 << DW) - 1)) - (longint'(1) << (DW - 1));
  endfunction

  function automatic longint rnd_trig();
    if ($urandom_range(0, 7) == 0) return rnd_data();
    return longint'($urandom_range(0, 65534)) - 32767;
  endfunction

  initial begin
    longint x0, y0, s0, c0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = PARK_FWD;
    bus.in_tag    = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_sin    = '0;
    bus.in_cos    = '0;
    bus.out_ready = 1'b1;
    bus.ovf_clr   = 1'b0;
    drv_done      = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_u", bus.out_u, 0);
    check("rst_out_v", bus.out_v, 0);
    check("rst_out_tag", longint'(bus.out_tag), 0);
    check("rst_out_ovf", longint'(bus.out_ovf), 0);
    check("rst_sticky", longint'(bus.ovf_sticky), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", longint'(bus.in_ready), 1);

    send(PARK_FWD, 1, 1000, -500, 0, 32767, 1'b1);
    idle();
    send(PARK_INV, 2, 1000, 0, 32767, 0, 1'b1);
    idle();
    drain();
    check("sticky_clean", longint'(bus.ovf_sticky), 0);

    send(PARK_FWD, 3, 131071, 131071, 32767, 32767, 1'b1);
    idle();
    drain();
    check("sticky_set", longint'(bus.ovf_sticky), 1);
    bus.ovf_clr = 1'b1;
    @(posedge clk); #1;
    bus.ovf_clr = 1'b0;
    check("sticky_clr", longint'(bus.ovf_sticky), 0);

    // Clear pulse lands on the same edge the overflowing result is loaded.
    send(PARK_FWD, 4, 131071, 131071, 32767, 32767, 1'b1);
    idle();
    @(posedge clk); #1;
    bus.ovf_clr = 1'b1;
    @(posedge clk); #1;
    bus.ovf_clr = 1'b0;
    check("sticky_set_wins", longint'(bus.ovf_sticky), 1);
    drain();
    bus.ovf_clr = 1'b1;
    @(posedge clk); #1;
    bus.ovf_clr = 1'b0;

    fork
      begin
        for (int i = 0; i < 8; i++) send(PARK_FWD, i, rnd_data(), rnd_data(), rnd_trig(),
                                         rnd_trig(), 1'b0);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (4) begin
          #1;
          check("stall_in_ready", longint'(bus.in_ready), 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    x0 = rnd_data();
    y0 = rnd_data();
    s0 = rnd_trig();
    c0 = rnd_trig();
    for (int i = 0; i < 8; i++) begin
      send((i % 2) ? PARK_INV : PARK_FWD, i + 8, x0, y0, s0, c0, 1'b1);
    end
    idle();
    drain();

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(park_mode_t'($urandom_range(0, 1)), int'($urandom_range(0, 15)), rnd_data(),
               rnd_data(), rnd_trig(), rnd_trig(), 1'b0);
          if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk); #1;
            end
          end
        end
        idle();
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(PARK_INV, i, rnd_data(), rnd_data(), rnd_trig(),
                                     rnd_trig(), 1'b0);
    idle();
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_out_valid", longint'(bus.out_valid), 0);
    check("async_rst_in_ready", longint'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", longint'(bus.out_valid), 0);
    check("post_rst_out_u", bus.out_u, 0);
    check("post_rst_out_tag", longint'(bus.out_tag), 0);
    check("post_rst_sticky", longint'(bus.ovf_sticky), 0);
    send(PARK_FWD, 5, 1000, -500, 0, 32767, 1'b1);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
